// File: rtl/formula_result_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : formula_result_reorder
//  Description : In-order result collector for the formula task distributor.
//                The issue side takes a tag for every dispatched argument
//                triple. Workers hand their results back tagged and possibly
//                out of order. Each result is held until every older tag has
//                retired, and results then leave strictly in issue order at
//                no more than one per cycle.
//
//  Ports
//    clk        in   clock
//    rst        in   synchronous active-high reset
//    alloc_req  in   distributor asks for a tag this cycle
//    alloc_rdy  out  a tag is free (registered count below DEPTH)
//    alloc_tag  out  tag granted when alloc_req && alloc_rdy
//    done_vld   in   a worker returns a result
//    done_tag   in   tag of the returned result
//    done_data  in   returned result value
//    res_vld    out  in-order result valid (registered)
//    res        out  in-order result value (registered, holds when idle)
//    err        out  sticky protocol-error flag, cleared only by rst
//
//  Revision    : 1.0  initial release
// ============================================================================
module formula_result_reorder #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_rdy,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              done_vld,
    input  logic [TAG_W-1:0]  done_tag,
    input  logic [DATA_W-1:0] done_data,
    output logic              res_vld,
    output logic [DATA_W-1:0] res,
    output logic              err
);

    localparam logic [TAG_W:0] c_FULL = (TAG_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  r_wr_ptr;
    logic [TAG_W-1:0]  r_rd_ptr;
    logic [TAG_W:0]    r_count;
    logic [DEPTH-1:0]  r_pending;   // tag handed out, not yet retired
    logic [DEPTH-1:0]  r_filled;    // result captured, waiting for its turn
    logic [DATA_W-1:0] r_data [DEPTH];

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic             w_alloc;
    logic             w_retire;
    logic             w_done_ok;
    logic             w_done_bad;
    logic [DEPTH-1:0] w_pending_nxt;
    logic [DEPTH-1:0] w_filled_nxt;

    // alloc_rdy looks only at the registered count, so a retire in the
    // same cycle as a full queue frees the slot one cycle later.
    assign alloc_rdy = (r_count != c_FULL);
    assign alloc_tag = r_wr_ptr;

    assign w_alloc  = alloc_req && alloc_rdy;
    assign w_retire = r_filled[r_rd_ptr];

    // A completion is accepted only for a live tag that has not already
    // reported. A tag allocated in this same cycle is not yet pending, and
    // a second report for a filled head is a double completion; both
    // count as errors.
    assign w_done_ok  = done_vld && r_pending[done_tag] && !r_filled[done_tag];
    assign w_done_bad = done_vld && !w_done_ok;

    // The three updates never hit the same entry in one cycle:
    //  - alloc and retire on one index would need count == 0 with a
    //    filled head, which cannot happen;
    //  - an accepted completion needs the entry pending, so it can be
    //    neither the freshly allocated one nor the retiring (filled) head.
    always_comb begin
        w_pending_nxt = r_pending;
        w_filled_nxt  = r_filled;
        if (w_retire) begin
            w_pending_nxt[r_rd_ptr] = 1'b0;
            w_filled_nxt[r_rd_ptr]  = 1'b0;
        end
        if (w_alloc) begin
            w_pending_nxt[r_wr_ptr] = 1'b1;
        end
        if (w_done_ok) begin
            w_filled_nxt[done_tag] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_filled  <= '0;
            res_vld   <= 1'b0;
            res       <= '0;
            err       <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_filled  <= w_filled_nxt;

            if (w_alloc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Output is fed from storage only; done_* never bypasses to res.
            if (w_retire) begin
                res      <= r_data[r_rd_ptr];
                res_vld  <= 1'b1;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                res_vld  <= 1'b0;
            end

            if (w_done_bad) begin
                err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result storage: contents are meaningless until the filled bit is set,
    // so no reset is needed here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_done_ok) begin
            r_data[done_tag] <= done_data;
        end
    end

endmodule
`default_nettype wire
